// File: rtl/regfile_pkg.sv
// Shared definitions for the register-bank write side.
// Contents: register index/data widths, the hard-wired $zero index, and the
// write-queue entry type (destination index + data).
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] idx;
    logic [REG_DATA_W-1:0] data;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Associative lookup of one read index against the writeback queue.
// Build option: WBQ_FORWARD_EN adds the youngest-hit data output.
// Ports:
//   entries_i  - queue storage, indexed by slot
//   valid_i    - per-slot occupancy mask
//   head_i     - slot of the oldest entry (start of age order)
//   rd_idx_i   - register index being read by decode
//   hit_data_o - data of the youngest matching entry, 0 if none (WBQ_FORWARD_EN only)
//   hit_o      - some valid entry targets rd_idx_i ($zero never hits)
module wbq_match
  import regfile_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  wbq_entry_t                   entries_i [Depth],
  input  logic [Depth-1:0]             valid_i,
  input  logic [$clog2(Depth)-1:0]     head_i,
  input  logic [REG_ADDR_W-1:0]        rd_idx_i,
`ifdef WBQ_FORWARD_EN
  output logic [REG_DATA_W-1:0]        hit_data_o,
`endif
  output logic                         hit_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0] slot;

  // Walk slots oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit_o = 1'b0;
    slot  = '0;
`ifdef WBQ_FORWARD_EN
    hit_data_o = '0;
`endif
    for (int k = 0; k < Depth; k++) begin
      slot = head_i + PtrW'(k);
      if (valid_i[slot] && (rd_idx_i != REG_ZERO) && (entries_i[slot].idx == rd_idx_i)) begin
        hit_o = 1'b1;
`ifdef WBQ_FORWARD_EN
        hit_data_o = entries_i[slot].data;
`endif
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writeback queue in front of the 32x32 register bank's single write port.
// Producers push (InReg, InData); entries retire in arrival order, one per
// cycle while PortGrant is high. Busy1/Busy2 flag reads of registers that
// still have a write queued.
// Build option: WBQ_FORWARD_EN adds Fwd1Valid/Fwd1Data/Fwd2Valid/Fwd2Data,
// carrying the youngest queued data for Read1/Read2 so decode can bypass.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   InValid/InReg/InData        - producer write offer; InReady = not full
//   PortGrant                   - bank write port free this cycle
//   RegWrite/WriteReg/WriteData - bank write port (head entry, 0 when empty)
//   Read1/Read2, Busy1/Busy2    - pending-write scoreboard per read port
//   Count                       - occupancy
module regfile_writeback_queue
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned DATA_W = REG_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     InValid,
  input  logic [ADDR_W-1:0]        InReg,
  input  logic [DATA_W-1:0]        InData,
  output logic                     InReady,
  input  logic                     PortGrant,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        WriteReg,
  output logic [DATA_W-1:0]        WriteData,
  input  logic [ADDR_W-1:0]        Read1,
  input  logic [ADDR_W-1:0]        Read2,
  output logic                     Busy1,
  output logic                     Busy2,
`ifdef WBQ_FORWARD_EN
  output logic                     Fwd1Valid,
  output logic [DATA_W-1:0]        Fwd1Data,
  output logic                     Fwd2Valid,
  output logic [DATA_W-1:0]        Fwd2Data,
`endif
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wbq_entry_t      mem_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid;
  logic            not_empty, push, pop;

  assign not_empty = (count_q != '0);
  assign InReady   = (count_q != CntW'(DEPTH));
  // Writes to $zero complete the handshake but never occupy a slot.
  assign push      = InValid && InReady && (REG_ADDR_W'(InReg) != REG_ZERO);
  assign RegWrite  = not_empty && PortGrant;
  assign pop       = RegWrite;
  assign Count     = count_q;

  assign WriteReg  = not_empty ? ADDR_W'(mem_q[head_q].idx)  : '0;
  assign WriteData = not_empty ? DATA_W'(mem_q[head_q].data) : '0;

  always_comb begin
    head_d  = pop  ? head_q + PtrW'(1) : head_q;
    tail_d  = push ? tail_q + PtrW'(1) : tail_q;
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // Slot i is occupied when its distance from head is below the occupancy.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = {1'b0, PtrW'(i) - head_q} < count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: the valid mask and not_empty gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= '{idx: REG_ADDR_W'(InReg), data: REG_DATA_W'(InData)};
    end
  end

`ifdef WBQ_FORWARD_EN
  logic [REG_DATA_W-1:0] fwd1_data, fwd2_data;

  assign Fwd1Valid = Busy1;
  assign Fwd2Valid = Busy2;
  assign Fwd1Data  = DATA_W'(fwd1_data);
  assign Fwd2Data  = DATA_W'(fwd2_data);
`endif

  wbq_match #(
    .Depth(DEPTH)
  ) u_match1 (
    .entries_i (mem_q),
    .valid_i   (valid),
    .head_i    (head_q),
    .rd_idx_i  (REG_ADDR_W'(Read1)),
`ifdef WBQ_FORWARD_EN
    .hit_data_o(fwd1_data),
`endif
    .hit_o     (Busy1)
  );

  wbq_match #(
    .Depth(DEPTH)
  ) u_match2 (
    .entries_i (mem_q),
    .valid_i   (valid),
    .head_i    (head_q),
    .rd_idx_i  (REG_ADDR_W'(Read2)),
`ifdef WBQ_FORWARD_EN
    .hit_data_o(fwd2_data),
`endif
    .hit_o     (Busy2)
  );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: directed pushes feed an expected-write
// queue; a negedge monitor pops and compares whenever RegWrite is high.
// Build option: WBQ_FORWARD_EN enables the forwarding checks.
module tb_regfile_writeback_queue;

  logic        clk;
  logic        rst_n;
  logic        InValid;
  logic [4:0]  InReg;
  logic [31:0] InData;
  logic        InReady;
  logic        PortGrant;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  Read1, Read2;
  logic        Busy1, Busy2;
  logic [2:0]  Count;
`ifdef WBQ_FORWARD_EN
  logic        Fwd1Valid, Fwd2Valid;
  logic [31:0] Fwd1Data, Fwd2Data;
`endif

  int          n_pass = 0;
  int          n_total = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  regfile_writeback_queue #(
    .DEPTH (4),
    .ADDR_W(5),
    .DATA_W(32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .InValid  (InValid),
    .InReg    (InReg),
    .InData   (InData),
    .InReady  (InReady),
    .PortGrant(PortGrant),
    .RegWrite (RegWrite),
    .WriteReg (WriteReg),
    .WriteData(WriteData),
    .Read1    (Read1),
    .Read2    (Read2),
    .Busy1    (Busy1),
    .Busy2    (Busy2),
`ifdef WBQ_FORWARD_EN
    .Fwd1Valid(Fwd1Valid),
    .Fwd1Data (Fwd1Data),
    .Fwd2Valid(Fwd2Valid),
    .Fwd2Data (Fwd2Data),
`endif
    .Count    (Count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want bench completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one write for one cycle; 'accept' says whether it should be queued.
  task automatic push(input logic [4:0] r, input logic [31:0] d, input bit accept);
    InValid = 1'b1;
    InReg   = r;
    InData  = d;
    if (accept) exp_q.push_back({r, d});
    tick();
    InValid = 1'b0;
  endtask

  // Scoreboard monitor: every bank write must match the oldest expectation.
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got reg %0d data 0x%0h, want no write",
                 WriteReg, WriteData);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_reg", 32'(WriteReg), 32'(mon_e[36:32]));
        check("write_data", WriteData, mon_e[31:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b1; InValid = 1'b0; InReg = '0; InData = '0;
    PortGrant = 1'b0; Read1 = 5'd3; Read2 = 5'd5;
    #1 rst_n = 1'b0;
    #2;
    // Reset state
    check("rst_count", 32'(Count), 0);
    check("rst_inready", 32'(InReady), 1);
    check("rst_regwrite", 32'(RegWrite), 0);
    check("rst_writereg", 32'(WriteReg), 0);
    check("rst_writedata", WriteData, 0);
    check("rst_busy1", 32'(Busy1), 0);
    check("rst_busy2", 32'(Busy2), 0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("idle_count", 32'(Count), 0);
    check("idle_inready", 32'(InReady), 1);
    check("idle_regwrite", 32'(RegWrite), 0);
    check("idle_busy1", 32'(Busy1), 0);

    // Single write
    PortGrant = 1'b1;
    push(5'd3, 32'hDEADBEEF, 1'b1);
    check("single_regwrite", 32'(RegWrite), 1);
    check("single_count", 32'(Count), 1);
    check("single_busy1", 32'(Busy1), 1);
    tick();
    check("single_regwrite_off", 32'(RegWrite), 0);
    check("single_count_back", 32'(Count), 0);
    check("single_busy1_off", 32'(Busy1), 0);

    // Fill and stall
    PortGrant = 1'b0;
    for (int i = 0; i < 4; i++) push(5'(i + 1), 32'h10 + 32'(i), 1'b1);
    check("full_count", 32'(Count), 4);
    check("full_inready", 32'(InReady), 0);
    push(5'd7, 32'h77, 1'b0);
    check("full_ignore_count", 32'(Count), 4);
    Read1 = 5'd2; Read2 = 5'd7;
    #1;
    check("full_busy1", 32'(Busy1), 1);
    check("full_busy2", 32'(Busy2), 0);
    PortGrant = 1'b1;
    #1;
    check("full_inready_grant", 32'(InReady), 0);
    tick();
    check("drain1_count", 32'(Count), 3);
    check("drain1_inready", 32'(InReady), 1);
    check("drain1_busy1", 32'(Busy1), 1);
    tick();
    check("drain2_count", 32'(Count), 2);
    check("drain2_busy1", 32'(Busy1), 0);
    tick(); tick();
    check("drain_done_count", 32'(Count), 0);

    // Zero-register push and simultaneous push/pop
    Read1 = 5'd0;
    InValid = 1'b1; InReg = 5'd0; InData = 32'h55;
    #1;
    check("zero_inready", 32'(InReady), 1);
    tick();
    InValid = 1'b0;
    check("zero_count", 32'(Count), 0);
    check("zero_regwrite", 32'(RegWrite), 0);
    check("zero_busy1", 32'(Busy1), 0);
    PortGrant = 1'b0;
    for (int i = 0; i < 3; i++) push(5'(i + 8), 32'hA0 + 32'(i), 1'b1);
    check("sim_pre_count", 32'(Count), 3);
    PortGrant = 1'b1;
    push(5'd11, 32'hA3, 1'b1);
    check("sim_count", 32'(Count), 3);
    tick(); tick(); tick();
    check("sim_drained", 32'(Count), 0);

    // Reset in the middle of a drain
    PortGrant = 1'b0;
    for (int i = 0; i < 3; i++) push(5'(i + 12), 32'hC0 + 32'(i), 1'b1);
    PortGrant = 1'b1;
    #1;
    check("mid_regwrite", 32'(RegWrite), 1);
    check("mid_writereg", 32'(WriteReg), 12);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_regwrite", 32'(RegWrite), 0);
    check("mid_rst_count", 32'(Count), 0);
    check("mid_rst_writedata", WriteData, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("post_rst_count", 32'(Count), 0);
    check("post_rst_regwrite", 32'(RegWrite), 0);

`ifdef WBQ_FORWARD_EN
    // Forwarding: youngest data wins
    PortGrant = 1'b0;
    Read1 = 5'd5;
    push(5'd5, 32'h11, 1'b1);
    push(5'd5, 32'h22, 1'b1);
    check("fwd_valid", 32'(Fwd1Valid), 1);
    check("fwd_data", Fwd1Data, 32'h22);
    check("fwd2_valid", 32'(Fwd2Valid), 0);
    PortGrant = 1'b1;
    tick();
    PortGrant = 1'b0;
    #1;
    check("fwd_pop1_valid", 32'(Fwd1Valid), 1);
    check("fwd_pop1_data", Fwd1Data, 32'h22);
    PortGrant = 1'b1;
    tick();
    PortGrant = 1'b0;
    #1;
    check("fwd_pop2_valid", 32'(Fwd1Valid), 0);
    check("fwd_pop2_data", Fwd1Data, 0);
`endif

    tick(); tick();
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
